// File: rtl/demux_dispatch_sched_pkg.sv
// ============================================================================
// Module      : demux_dispatch_pkg
// Description : Shared types and helpers for the demux dispatch scheduler.
//               Holds the scheduler state encoding, the statistics counter
//               width and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  localparam int STAT_W     = 32;
  // Widest lane vector the one-hot helper can decode; callers size-cast
  // the result down to their own lane count.
  localparam int ONEHOT_MAX = 32;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [31:0] idx);
    return {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_dispatch_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search. Returns the first
//               requesting lane at or after ptr, wrapping past NUMBER-1.
//               The pointer itself is owned by the parent.
// Ports       : req   - per-lane request vector
//               ptr   - lane with highest priority this round
//               grant - index of the selected lane (0 when any=0)
//               any   - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUMBER   = 4,
  parameter int SELECT_W = $clog2(NUMBER)
) (
  input  logic [NUMBER-1:0]   req,
  input  logic [SELECT_W-1:0] ptr,
  output logic [SELECT_W-1:0] grant,
  output logic                any
);

  int                  w_idx;
  logic [SELECT_W-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the last hit written is
  // the lane closest to ptr; this avoids a loop break.
  always_comb begin
    grant  = '0;
    w_idx  = 0;
    w_cand = '0;
    for (int i = NUMBER - 1; i >= 0; i--) begin
      w_idx  = (int'(ptr) + i) % NUMBER;
      w_cand = SELECT_W'(w_idx);
      if (req[w_cand]) begin
        grant = w_cand;
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/demux_dispatch_sched.sv
// ============================================================================
// Module      : demux_dispatch_sched
// Description : Round-robin burst scheduler sharing one word stream among
//               NUMBER consumer lanes. A granted lane receives exactly its
//               requested number of words through a single output register
//               (1-cycle latency, full throughput), then arbitration resumes.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_data/valid/ready - source stream
//               req_valid/len/ack   - per-lane burst requests
//               sel                 - demux select (granted lane)
//               out_data/valid/ready/last - registered per-lane output
//               busy                - high while a grant is in progress
// Options     : DISPATCH_STATS_EN adds stat_clr input and stat_words output
//               (per-lane delivered word counters, synchronous clear).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_dispatch_sched
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUMBER = 4,
  parameter int LEN_W  = 8,
  localparam int SELECT_W = $clog2(NUMBER)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUMBER-1:0]   req_valid,
  input  logic [LEN_W-1:0]    req_len [NUMBER-1:0],
  output logic [NUMBER-1:0]   req_ack,
  output logic [SELECT_W-1:0] sel,
  output logic [WIDTH-1:0]    out_data,
  output logic [NUMBER-1:0]   out_valid,
  input  logic [NUMBER-1:0]   out_ready,
  output logic                out_last,
  output logic                busy
`ifdef DISPATCH_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [STAT_W-1:0]   stat_words [NUMBER]
`endif
);

  sched_state_t        r_state;
  sched_state_t        w_next;
  logic [SELECT_W-1:0] r_rr_ptr;
  logic [LEN_W-1:0]    r_remain;
  logic [SELECT_W-1:0] w_win;
  logic                w_any;
  logic [NUMBER-1:0]   w_sel_oh;
  logic                w_out_full;
  logic                w_sel_ready;
  logic                w_can_load;
  logic                w_accept;
  logic [SELECT_W-1:0] w_ptr_next;

  rr_arbiter #(
    .NUMBER   (NUMBER),
    .SELECT_W (SELECT_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_win),
    .any   (w_any)
  );

  assign w_sel_oh    = NUMBER'(onehot(32'(sel)));
  assign w_out_full  = |(out_valid & w_sel_oh);
  assign w_sel_ready = |(out_ready & w_sel_oh);
  // The output register can take a word if it is empty or is being drained
  // by the granted lane in this same cycle.
  assign w_can_load  = !w_out_full || w_sel_ready;
  assign in_ready    = (r_state == XFER) && w_can_load;
  assign w_accept    = in_valid && in_ready;
  assign req_ack     = (r_state == GRANT) ? w_sel_oh : '0;
  assign busy        = (r_state != IDLE);
  assign w_ptr_next  = (sel == SELECT_W'(NUMBER - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = GRANT;
      GRANT:   w_next = (req_len[sel] == '0) ? IDLE : XFER;
      XFER:    if (w_accept && (r_remain == LEN_W'(1))) w_next = DRAIN;
      DRAIN:   if (w_can_load) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // sel is latched on the IDLE->GRANT edge so req_ack and sel already agree
  // during the GRANT cycle; the output register is empty whenever that
  // happens, so no in-flight word sees the select move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_remain  <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= '0;
      out_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any) sel <= w_win;
        end
        GRANT: begin
          r_remain <= req_len[sel];
          if (req_len[sel] == '0) r_rr_ptr <= w_ptr_next;
        end
        XFER: begin
          if (w_accept) begin
            out_data  <= in_data;
            out_valid <= w_sel_oh;
            out_last  <= (r_remain == LEN_W'(1));
            r_remain  <= r_remain - 1'b1;
          end else if (w_sel_ready) begin
            out_valid <= '0;
            out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_can_load) begin
            out_valid <= '0;
            out_last  <= 1'b0;
            r_rr_ptr  <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  // Clear takes priority over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER; i++) stat_words[i] <= '0;
    end else begin
      for (int i = 0; i < NUMBER; i++) begin
        if (stat_clr) begin
          stat_words[i] <= '0;
        end else if (out_valid[i] && out_ready[i]) begin
          stat_words[i] <= stat_words[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatch_sched.sv
// ============================================================================
// Module      : tb_demux_dispatch_sched
// Description : Self-checking bench for demux_dispatch_sched. A source/sink
//               engine drives the stream and records accepted and delivered
//               words; a round-robin model predicts grant order and the
//               per-burst word layout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_demux_dispatch_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_len [3:0];
  logic [3:0]  req_ack;
  logic [1:0]  sel;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        out_last;
  logic        busy;
`ifdef DISPATCH_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_words [4];
`endif

  demux_dispatch_sched #(.WIDTH(64), .NUMBER(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ack   (req_ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_words(stat_words)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int lane; logic [63:0] data; logic last; int cyc; int sel;} word_t;
  typedef struct {int lane; logic last;} exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_stall = 0;
  int          src_mode = 0;
  int          snk_mode = 0;
  int          m_ptr = 0;
  int          tb_len [4];
  word_t       dq [$];
  logic [63:0] sent [$];
  int          acks [$];
  int          exp_g [$];
  exp_t        exp_w [$];

  function automatic int idx_of(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  // Reference: with mask held, n grants follow round-robin from m_ptr and
  // each grant produces tb_len[lane] words, the final one marked last.
  task automatic model_run(input logic [3:0] mask, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      w = rr_pick(mask, m_ptr);
      exp_g.push_back(w);
      for (int j = 0; j < tb_len[w]; j++) exp_w.push_back('{lane: w, last: (j == tb_len[w] - 1)});
      m_ptr = (w + 1) % 4;
    end
  endtask

  // Source/sink engine: drive at negedge, sample 1 ns before posedge.
  initial begin
    logic        src_new;
    logic        prev_stall;
    logic [3:0]  prev_valid;
    logic [63:0] prev_data;
    logic        prev_last;
    src_new = 1'b0; prev_stall = 1'b0; prev_valid = '0; prev_data = '0; prev_last = 1'b0;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    out_ready = '1;
    forever begin
      @(negedge clk);
      cyc++;
      if (src_new) begin in_data = {$urandom, $urandom}; src_new = 1'b0; end
      in_valid = (src_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (snk_mode)
        0:       out_ready = '1;
        1:       out_ready = 4'($urandom);
        default: out_ready = (cyc % 3 == 0) ? 4'b1111 : 4'b0000;
      endcase
      #4;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (in_valid && in_ready) begin sent.push_back(in_data); src_new = 1'b1; end
        if (req_ack != 0) acks.push_back(idx_of(req_ack));
        if (out_valid != 0) begin
          checks++;
          if (out_valid !== (4'b0001 << sel)) begin
            errors++; $display("FAIL onehot: out_valid=%b sel=%0d required one-hot of sel", out_valid, sel);
          end
          if ((out_valid & out_ready) != 0)
            dq.push_back('{lane: idx_of(out_valid), data: out_data, last: out_last, cyc: cyc, sel: int'(sel)});
        end
        if (prev_stall) begin
          checks++;
          if (out_valid !== prev_valid || out_data !== prev_data || out_last !== prev_last) begin
            errors++; $display("FAIL stall_hold: got v=%b d=%h required v=%b d=%h", out_valid, out_data, prev_valid, prev_data);
          end
        end
        if ((out_valid & ~out_ready) != 0) begin
          checks++; n_stall++;
          if (in_ready !== 1'b0) begin
            errors++; $display("FAIL inready_full: in_ready=%b required 0", in_ready);
          end
        end
        prev_stall = (out_valid != 0) && ((out_valid & out_ready) == 0);
        prev_valid = out_valid; prev_data = out_data; prev_last = out_last;
      end
    end
  end

  task automatic set_lens(input int a, input int b, input int c, input int d);
    tb_len[0] = a; tb_len[1] = b; tb_len[2] = c; tb_len[3] = d;
    for (int k = 0; k < 4; k++) req_len[k] = 8'(tb_len[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; src_mode = 0; snk_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dq.delete(); sent.delete(); acks.delete(); exp_g.delete(); exp_w.delete();
    m_ptr = 0;
  endtask

  // Hold mask until n more grants are seen, then wait for the burst to end.
  task automatic run(input logic [3:0] mask, input int n, input int budget);
    int t;
    int base;
    base = acks.size();
    t = 0;
    @(negedge clk);
    req_valid = mask;
    while (acks.size() < base + n && t < budget) begin @(negedge clk); t++; end
    req_valid = '0;
    while ((busy || out_valid != 0) && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (t >= budget) begin
      errors++; $display("FAIL run_timeout: acks=%0d busy=%b required %0d acks and idle", acks.size() - base, busy, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111; set_lens(1, 1, 1, 1);
    @(negedge clk);
    checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data: got %h required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL rst_req_ack: got %b required 0", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d required 0", sel); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_lane();
    do_reset();
    set_lens(0, 3, 0, 0);
    model_run(4'b0010, 1);
    run(4'b0010, 1, 100);
    checks++; if (acks.size() !== 1 || acks[0] !== 1) begin errors++; $display("FAIL t1_ack: got n=%0d required lane 1", acks.size()); end
    checks++; if (dq.size() !== 3 || sent.size() !== 3) begin errors++; $display("FAIL t1_count: got %0d/%0d required 3", dq.size(), sent.size()); end
    for (int k = 0; k < dq.size() && k < exp_w.size() && k < sent.size(); k++) begin
      checks++;
      if (dq[k].lane !== exp_w[k].lane || dq[k].last !== exp_w[k].last || dq[k].data !== sent[k] || dq[k].sel !== 1) begin
        errors++; $display("FAIL t1_word%0d: got lane=%0d last=%b d=%h required lane=%0d last=%b d=%h", k, dq[k].lane, dq[k].last, dq[k].data, exp_w[k].lane, exp_w[k].last, sent[k]);
      end
      if (k > 0) begin
        checks++;
        if (dq[k].cyc !== dq[k-1].cyc + 1) begin errors++; $display("FAIL t1_consecutive: gap %0d required 1", dq[k].cyc - dq[k-1].cyc); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle: busy=%b required 0", busy); end
    // Pointer now at 2: with lanes 0,1,3 requesting, lane 3 must win.
    set_lens(1, 1, 1, 1);
    model_run(4'b1011, 1);
    run(4'b1011, 1, 100);
    checks++; if (acks[acks.size()-1] !== exp_g[exp_g.size()-1]) begin errors++; $display("FAIL t1_ptr: got lane %0d required %0d", acks[acks.size()-1], exp_g[exp_g.size()-1]); end
  endtask

  task automatic test_all_lanes();
    do_reset();
    set_lens(2, 2, 2, 2);
    model_run(4'b1111, 5);
    run(4'b1111, 5, 300);
    checks++; if (acks.size() !== exp_g.size()) begin errors++; $display("FAIL t2_ack_count: got %0d required %0d", acks.size(), exp_g.size()); end
    for (int k = 0; k < acks.size() && k < exp_g.size(); k++) begin
      checks++; if (acks[k] !== exp_g[k]) begin errors++; $display("FAIL t2_order%0d: got lane %0d required %0d", k, acks[k], exp_g[k]); end
    end
    checks++; if (dq.size() !== exp_w.size() || sent.size() !== exp_w.size()) begin errors++; $display("FAIL t2_count: got %0d/%0d required %0d", dq.size(), sent.size(), exp_w.size()); end
    for (int k = 0; k < dq.size() && k < exp_w.size() && k < sent.size(); k++) begin
      checks++;
      if (dq[k].lane !== exp_w[k].lane || dq[k].last !== exp_w[k].last || dq[k].data !== sent[k]) begin
        errors++; $display("FAIL t2_word%0d: got lane=%0d last=%b required lane=%0d last=%b", k, dq[k].lane, dq[k].last, exp_w[k].lane, exp_w[k].last);
      end
    end
  endtask

  task automatic test_backpressure();
    int stalls0;
    do_reset();
    stalls0 = n_stall;
    snk_mode = 2;
    set_lens(0, 0, 5, 0);
    model_run(4'b0100, 1);
    run(4'b0100, 1, 200);
    snk_mode = 0;
    checks++; if (n_stall <= stalls0) begin errors++; $display("FAIL t3_stalled: got %0d stall cycles required >0", n_stall - stalls0); end
    checks++; if (dq.size() !== 5 || sent.size() !== 5) begin errors++; $display("FAIL t3_count: got %0d/%0d required 5", dq.size(), sent.size()); end
    for (int k = 0; k < dq.size() && k < exp_w.size() && k < sent.size(); k++) begin
      checks++;
      if (dq[k].lane !== exp_w[k].lane || dq[k].last !== exp_w[k].last || dq[k].data !== sent[k]) begin
        errors++; $display("FAIL t3_word%0d: got lane=%0d d=%h required lane=%0d d=%h", k, dq[k].lane, dq[k].data, exp_w[k].lane, sent[k]);
      end
    end
  endtask

  task automatic test_zero_length();
    int nwords;
    do_reset();
    set_lens(0, 2, 0, 0);
    model_run(4'b0010, 1);
    run(4'b0010, 1, 100);
    set_lens(0, 0, 0, 0);
    nwords = dq.size();
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL t4_ack: got %b required 1000", req_ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_grant: got %b required 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ack !== 4'b0) begin errors++; $display("FAIL t4_idle: busy=%b ack=%b required 0/0000", busy, req_ack); end
    checks++; if (dq.size() !== nwords) begin errors++; $display("FAIL t4_no_words: got %0d required %0d", dq.size() - nwords, 0); end
    m_ptr = 0;
    set_lens(1, 0, 0, 1);
    exp_g.delete(); acks.delete();
    model_run(4'b1001, 1);
    run(4'b1001, 1, 100);
    checks++; if (acks.size() !== 1 || acks[0] !== exp_g[0]) begin errors++; $display("FAIL t4_ptr: got lane %0d required %0d", acks.size() ? acks[0] : -1, exp_g[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int t;
    do_reset();
    set_lens(0, 6, 1, 0);
    model_run(4'b0100, 1);
    run(4'b0100, 1, 100);
    dq.delete();
    t = 0;
    @(negedge clk);
    req_valid = 4'b0010;
    while (dq.size() < 2 && t < 100) begin @(negedge clk); t++; end
    checks++; if (t >= 100) begin errors++; $display("FAIL t5_timeout: got %0d words required 2", dq.size()); end
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (out_valid !== 4'b0 || out_last !== 1'b0 || out_data !== 64'd0) begin errors++; $display("FAIL t5_out_reset: v=%b l=%b d=%h required zeros", out_valid, out_last, out_data); end
    checks++; if (busy !== 1'b0 || sel !== 2'd0 || req_ack !== 4'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL t5_ctl_reset: busy=%b sel=%0d ack=%b rdy=%b required zeros", busy, sel, req_ack, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    dq.delete(); sent.delete(); acks.delete(); exp_g.delete(); exp_w.delete();
    m_ptr = 0;
    set_lens(1, 1, 1, 1);
    model_run(4'b1111, 1);
    run(4'b1111, 1, 100);
    checks++; if (acks.size() !== 1 || acks[0] !== exp_g[0]) begin errors++; $display("FAIL t5_regrant: got lane %0d required %0d", acks.size() ? acks[0] : -1, exp_g[0]); end
    checks++; if (dq.size() !== 1 || sent.size() !== 1 || dq[0].lane !== 0 || dq[0].data !== sent[0] || dq[0].last !== 1'b1) begin errors++; $display("FAIL t5_word: got n=%0d required 1 word on lane 0", dq.size()); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    do_reset();
    src_mode = 1;
    snk_mode = 1;
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(1, 15));
      set_lens($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      model_run(mask, $urandom_range(1, 5));
      run(mask, exp_g.size() - acks.size(), 1000);
    end
    src_mode = 0;
    snk_mode = 0;
    checks++; if (acks.size() !== exp_g.size()) begin errors++; $display("FAIL rnd_ack_count: got %0d required %0d", acks.size(), exp_g.size()); end
    for (int k = 0; k < acks.size() && k < exp_g.size(); k++) begin
      checks++; if (acks[k] !== exp_g[k]) begin errors++; $display("FAIL rnd_order%0d: got lane %0d required %0d", k, acks[k], exp_g[k]); end
    end
    checks++; if (dq.size() !== exp_w.size() || sent.size() !== exp_w.size()) begin errors++; $display("FAIL rnd_count: got %0d/%0d required %0d", dq.size(), sent.size(), exp_w.size()); end
    for (int k = 0; k < dq.size() && k < exp_w.size() && k < sent.size(); k++) begin
      checks++;
      if (dq[k].lane !== exp_w[k].lane || dq[k].last !== exp_w[k].last || dq[k].data !== sent[k]) begin
        errors++; $display("FAIL rnd_word%0d: got lane=%0d last=%b required lane=%0d last=%b", k, dq[k].lane, dq[k].last, exp_w[k].lane, exp_w[k].last);
      end
    end
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    int cnt [4];
    do_reset();
    set_lens(2, 2, 2, 2);
    model_run(4'b1111, 10);
    run(4'b1111, 10, 500);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int k = 0; k < exp_w.size(); k++) cnt[exp_w[k].lane]++;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (stat_words[k] !== 32'(cnt[k])) begin errors++; $display("FAIL stat_lane%0d: got %0d required %0d", k, stat_words[k], cnt[k]); end
    end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (stat_words[k] !== 32'd0) begin errors++; $display("FAIL stat_clr%0d: got %0d required 0", k, stat_words[k]); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_lens(0, 0, 0, 0);
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_backpressure();
    test_zero_length();
    test_reset_mid_burst();
    test_random();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
